mlp_sample_feeder: RTL and testbench

- Driver side of the MLP classifier interface.
- Accepts one input sample as a stream of NUM_INPUTS fixed-point bytes over a valid/ready handshake, then packs them into the MLP's wide `data` bus.
- Releases the MLP from reset and waits for its one-cycle `ready` pulse, then captures `label`.
- Presents the label on a valid/ready output handshake.
- Sits between the testbench or DMA source and the MLP top; owns the MLP's reset and sequencing.

---
 rtl/mlp_sample_feeder_pkg.sv | 15 +
 rtl/mlp_sample_feeder_input_packer.sv | 38 +++
 rtl/mlp_sample_feeder.sv | 136 +++++++++++++
 tb/tb_mlp_sample_feeder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_sample_feeder_pkg.sv
// Shared definitions for the MLP sample feeder: controller state encoding and
// default geometry constants that the MLP top also uses.
package mlp_sample_feeder_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int MLP_N          = 8;
  localparam int MLP_NUM_INPUTS = 62;
  localparam int MLP_LABEL_W    = 4;

endpackage

// File: rtl/mlp_sample_feeder_input_packer.sv
// Packs a stream of N-bit values into one wide register, lowest index first;
// o_full strobes combinationally on the write that completes the sample.
module mlp_input_packer
  import mlp_sample_feeder_pkg::*;
#(
  parameter int N          = MLP_N,
  parameter int NUM_INPUTS = MLP_NUM_INPUTS,
  parameter int IDX_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr,
  input  logic [N-1:0]          i_dat,
  output logic [NUM_INPUTS*N-1:0] o_data,
  output logic                  o_full
);

  logic [IDX_W-1:0]          r_idx;
  logic [NUM_INPUTS*N-1:0]   r_data;
  logic                      w_last;

  assign w_last = (r_idx == IDX_W'(NUM_INPUTS - 1));
  assign o_full = i_wr & w_last;
  assign o_data = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_data <= '0;
    end else if (i_wr) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (r_idx == IDX_W'(k)) r_data[k*N +: N] <= i_dat;
      end
    end
  end

endmodule

// File: rtl/mlp_sample_feeder.sv
// Loads one sample into the MLP data bus, runs the MLP and returns its label.
// Optional watchdog on the RUN phase: define MLP_FEEDER_TIMEOUT_EN.
module mlp_sample_feeder
  import mlp_sample_feeder_pkg::*;
#(
  parameter int N                = MLP_N,
  parameter int NUM_INPUTS       = MLP_NUM_INPUTS,
  parameter int CLOG2_NUM_INPUTS = 6,
  parameter int LABEL_W          = MLP_LABEL_W,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic [N-1:0]            in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_INPUTS*N-1:0] mlp_data,
  output logic                    mlp_rst,
  input  logic                    mlp_ready,
  input  logic [LABEL_W-1:0]      mlp_label,
  output logic [LABEL_W-1:0]      label,
  output logic                    label_valid,
  input  logic                    label_ready,
  output logic                    error,
  output logic [15:0]             sample_count
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_wr;
  logic                 w_full;
  logic                 w_hit;
  logic                 w_timeout;
  logic                 r_run_first;
  logic                 r_mlp_rst;
  logic [LABEL_W-1:0]   r_label;
  logic                 r_label_valid;
  logic [15:0]          r_sample_count;

  mlp_input_packer #(
    .N          (N),
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (CLOG2_NUM_INPUTS)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .i_wr   (w_wr),
    .i_dat  (in_data),
    .o_data (mlp_data),
    .o_full (w_full)
  );

  // The MLP is released in the first RUN cycle, so a ready seen then is stale.
  assign w_hit = (r_state == RUN) & ~r_run_first & mlp_ready;

`ifdef MLP_FEEDER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (clk_en) begin
      r_to_cnt <= (r_state == RUN) ? r_to_cnt + 1'b1 : '0;
    end
  end

  assign w_timeout = (r_state == RUN) & ~w_hit & (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (clk_en) begin
      if (w_hit)          r_error <= 1'b0;
      else if (w_timeout) r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)         r_state <= LOAD;
    else if (clk_en) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_full) w_state_nxt = RUN;
      RUN:     if (w_hit | w_timeout) w_state_nxt = OUT;
      OUT:     if (r_label_valid & label_ready) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready = (r_state == LOAD) & clk_en;
    w_wr     = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_first    <= 1'b0;
      r_mlp_rst      <= 1'b1;
      r_label        <= '0;
      r_label_valid  <= 1'b0;
      r_sample_count <= '0;
    end else if (clk_en) begin
      r_run_first <= (r_state != RUN);
      r_mlp_rst   <= (w_state_nxt != RUN);
      if (w_hit) begin
        r_label        <= mlp_label;
        r_label_valid  <= 1'b1;
        r_sample_count <= r_sample_count + 16'd1;
      end else if (w_timeout) begin
        r_label        <= '1;
        r_label_valid  <= 1'b1;
        r_sample_count <= r_sample_count + 16'd1;
      end else if ((r_state == OUT) & r_label_valid & label_ready) begin
        r_label_valid <= 1'b0;
      end
    end
  end

  assign mlp_rst      = r_mlp_rst;
  assign label        = r_label;
  assign label_valid  = r_label_valid;
  assign sample_count = r_sample_count;

endmodule

// File: tb/tb_mlp_sample_feeder.sv
// Directed bench for mlp_sample_feeder: table of whole-sample transactions
// plus hand sequences for backpressure, clock enable, reset abort and timeout.
module tb_mlp_sample_feeder;

  localparam int N  = 8;
  localparam int NI = 62;
  localparam int LW = 4;
`ifdef MLP_FEEDER_TIMEOUT_EN
  localparam int TO = 16;
  localparam int D0 = 12;
`else
  localparam int TO = 4096;
  localparam int D0 = 40;
`endif

  logic              clk = 1'b0;
  logic              rst, clk_en, in_valid, in_ready;
  logic [N-1:0]      in_data;
  logic [NI*N-1:0]   mlp_data;
  logic              mlp_rst, mlp_ready, label_valid, label_ready, error;
  logic [LW-1:0]     mlp_label, label;
  logic [15:0]       sample_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mlp_sample_feeder #(
    .N(N), .NUM_INPUTS(NI), .CLOG2_NUM_INPUTS(6), .LABEL_W(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mlp_data(mlp_data), .mlp_rst(mlp_rst),
    .mlp_ready(mlp_ready), .mlp_label(mlp_label),
    .label(label), .label_valid(label_valid), .label_ready(label_ready),
    .error(error), .sample_count(sample_count)
  );

  typedef struct {
    logic [7:0]  base;
    bit          inc;
    bit          toggle;
    int          delay;
    logic [3:0]  lbl;
    int          exp_cycles;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;
    logic [3:0]  exp_label;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic [NI*N-1:0] act, input logic [NI*N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NI*N-1:0] pattern(input logic [7:0] base, input bit inc);
    logic [NI*N-1:0] v;
    for (int i = 0; i < NI; i++) v[i*N +: N] = inc ? 8'(base + i) : base;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents values base(+i) for indices [s,e); returns cycles spent.
  task automatic send_vals(input logic [7:0] base, input bit inc, input bit toggle,
                           input int s, input int e, output int cycles);
    int  acc = s;
    int  n   = 0;
    bit  ph  = 1'b1;
    bit  early = 1'b0;
    while (acc < e && n < 2000) begin
      in_valid = toggle ? ph : 1'b1;
      ph       = ~ph;
      in_data  = inc ? 8'(base + acc) : base;
      #1;
      if (mlp_rst !== 1'b1) early = 1'b1;
      if (in_valid && in_ready) acc++;
      tick();
      n++;
    end
    in_valid = 1'b0;
    cycles   = n;
    check("mlp_rst_high_during_load", {63'd0, early}, 64'd0);
    if (e == NI) check("mlp_rst_low_after_load", {63'd0, mlp_rst}, 64'd0);
  endtask

  // Model MLP: pulses ready at RUN cycle index `delay` with label `lbl`.
  task automatic run_mlp(input int delay, input logic [3:0] lbl);
    bit bad = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < delay; i++) begin
      #1;
      if (in_ready !== 1'b0 || label_valid !== 1'b0 || mlp_rst !== 1'b0) bad = 1'b1;
      tick();
    end
    mlp_ready = 1'b1;
    mlp_label = lbl;
    #1;
    if (label_valid !== 1'b0) bad = 1'b1;
    tick();
    mlp_ready = 1'b0;
    mlp_label = '0;
    in_valid  = 1'b0;
    check("run_phase_quiet", {63'd0, bad}, 64'd0);
  endtask

  task automatic drain();
    label_ready = 1'b1;
    #1;
    check("drain_in_ready_same_cycle", {63'd0, in_ready}, 64'd0);
    tick();
    label_ready = 1'b0;
    check("drain_label_valid_fall", {63'd0, label_valid}, 64'd0);
    check("drain_in_ready_rise", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit bad;
    logic [NI*N-1:0] snap;

    vecs[0] = '{8'h00, 1'b1, 1'b0, D0, 4'h4,  62, 8'h00, 8'h3D, 4'h4, 16'd1};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 3,  4'h9, 123, 8'h00, 8'h3D, 4'h9, 16'd2};
    vecs[2] = '{8'hA0, 1'b1, 1'b0, 1,  4'hC,  62, 8'hA0, 8'hDD, 4'hC, 16'd3};

    rst = 1'b1; clk_en = 1'b1; in_valid = 1'b0; in_data = '0;
    mlp_ready = 1'b0; mlp_label = '0; label_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_mlp_rst", {63'd0, mlp_rst}, 64'd1);
    check("reset_label", {60'd0, label}, 64'd0);
    check("reset_label_valid", {63'd0, label_valid}, 64'd0);
    check("reset_error", {63'd0, error}, 64'd0);
    check("reset_count", {48'd0, sample_count}, 64'd0);
    check_bus("reset_mlp_data", mlp_data, '0);

    for (int v = 0; v < 3; v++) begin
      send_vals(vecs[v].base, vecs[v].inc, vecs[v].toggle, 0, NI, cyc);
      check("load_cycles", 64'(cyc), 64'(vecs[v].exp_cycles));
      run_mlp(vecs[v].delay, vecs[v].lbl);
      check("label", {60'd0, label}, {60'd0, vecs[v].exp_label});
      check("label_valid", {63'd0, label_valid}, 64'd1);
      check("error_clear", {63'd0, error}, 64'd0);
      check("count", {48'd0, sample_count}, {48'd0, vecs[v].exp_count});
      check("out_mlp_rst", {63'd0, mlp_rst}, 64'd1);
      check("data_lo", {56'd0, mlp_data[7:0]}, {56'd0, vecs[v].exp_lo});
      check("data_hi", {56'd0, mlp_data[495:488]}, {56'd0, vecs[v].exp_hi});
      check_bus("data_full", mlp_data, pattern(vecs[v].base, vecs[v].inc));
      drain();
    end

    // Consumer stalls; late MLP pulses in OUT must not disturb the label.
    send_vals(8'h10, 1'b1, 1'b0, 0, NI, cyc);
    run_mlp(5, 4'h6);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mlp_ready = i[0];
      mlp_label = 4'h3;
      #1;
      if (label !== 4'h6 || label_valid !== 1'b1 || in_ready !== 1'b0 || mlp_rst !== 1'b1) bad = 1'b1;
      tick();
    end
    mlp_ready = 1'b0;
    check("backpressure_hold", {63'd0, bad}, 64'd0);
    check("backpressure_label", {60'd0, label}, 64'h6);
    check("backpressure_count", {48'd0, sample_count}, 64'd4);
    drain();

    // Clock enable stall mid-load and mid-run; first RUN cycle ready ignored.
    send_vals(8'h40, 1'b1, 1'b0, 0, 10, cyc);
    clk_en = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (in_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    in_valid = 1'b0; clk_en = 1'b1;
    check("clk_en_no_accept", {63'd0, bad}, 64'd0);
    check("clk_en_byte9", {56'd0, mlp_data[79:72]}, 64'h49);
    check("clk_en_byte10_old", {56'd0, mlp_data[87:80]}, 64'h1A);
    send_vals(8'h40, 1'b1, 1'b0, 10, NI, cyc);
    check("clk_en_resume_cycles", 64'(cyc), 64'd52);
    mlp_ready = 1'b1; mlp_label = 4'h1;
    tick();
    check("first_run_ready_ignored", {63'd0, label_valid}, 64'd0);
    check("first_run_still_run", {63'd0, mlp_rst}, 64'd0);
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("run_stall_no_label", {63'd0, label_valid}, 64'd0);
    check("run_stall_mlp_rst", {63'd0, mlp_rst}, 64'd0);
    clk_en = 1'b1; mlp_ready = 1'b0; mlp_label = '0;
    run_mlp(3, 4'hA);
    check("clk_en_label", {60'd0, label}, 64'hA);
    check("clk_en_count", {48'd0, sample_count}, 64'd5);
    check_bus("clk_en_data", mlp_data, pattern(8'h40, 1'b1));
    drain();

    // Reset mid-load discards the partial sample.
    send_vals(8'h80, 1'b1, 1'b0, 0, 30, cyc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_bus("abort_data_cleared", mlp_data, '0);
    check("abort_count", {48'd0, sample_count}, 64'd0);
    check("abort_no_label", {63'd0, label_valid}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    send_vals(8'hFF, 1'b0, 1'b0, 0, NI, cyc);
    check("abort_reload_cycles", 64'(cyc), 64'd62);
    run_mlp(4, 4'h2);
    check_bus("abort_data_ff", mlp_data, pattern(8'hFF, 1'b0));
    check("abort_label", {60'd0, label}, 64'h2);
    check("abort_count_after", {48'd0, sample_count}, 64'd1);
    drain();

    // MLP never responds.
    send_vals(8'h00, 1'b1, 1'b0, 0, NI, cyc);
`ifdef MLP_FEEDER_TIMEOUT_EN
    cyc = 0;
    while (label_valid !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("timeout_run_cycles", 64'(cyc), 64'd16);
    check("timeout_label", {60'd0, label}, 64'hF);
    check("timeout_error", {63'd0, error}, 64'd1);
    check("timeout_count", {48'd0, sample_count}, 64'd2);
    check("timeout_mlp_rst", {63'd0, mlp_rst}, 64'd1);
    drain();
`else
    for (int i = 0; i < 100; i++) tick();
    check("no_timeout_label_valid", {63'd0, label_valid}, 64'd0);
    check("no_timeout_mlp_rst", {63'd0, mlp_rst}, 64'd0);
    check("no_timeout_error", {63'd0, error}, 64'd0);
    check("no_timeout_count", {48'd0, sample_count}, 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
